// File: rtl/hazard_sequencer.sv
// Pipeline hazard sequencer: operand forwarding, load-use and branch handling,
// multi-cycle MDU stall with timeout, and debug halt/single-step control.
module hazard_sequencer #(
  parameter int MDU_TIMEOUT = 40
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  Rs1D,
  input  logic [4:0]  Rs2D,
  input  logic [4:0]  Rs1E,
  input  logic [4:0]  Rs2E,
  input  logic [4:0]  RdE,
  input  logic [1:0]  ResultSrcE,
  input  logic        PCSrcE,
  input  logic        mdu_opE,
  input  logic        mdu_done,
  input  logic [4:0]  RdM,
  input  logic [4:0]  RdW,
  input  logic        RegWriteM,
  input  logic        RegWriteW,
  input  logic        halt_req,
  input  logic        step_req,
  output logic        StallF,
  output logic        StallD,
  output logic        StallE,
  output logic        FlushD,
  output logic        FlushE,
  output logic        BubbleM,
  output logic [1:0]  ForwardAE,
  output logic [1:0]  ForwardBE,
  output logic        mdu_start,
  output logic        halted,
  output logic        mdu_err,
  output logic [31:0] stall_cnt
);

  localparam int CW = (MDU_TIMEOUT > 1) ? $clog2(MDU_TIMEOUT) : 1;

  typedef enum logic [1:0] {
    S_RUN      = 2'd0,
    S_MDU_WAIT = 2'd1,
    S_HALTED   = 2'd2,
    S_STEP     = 2'd3
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [CW-1:0] wait_cnt;
  logic          wait_last;
  logic          lw_stall;

  assign lw_stall  = (ResultSrcE == 2'b01) && (RdE != 5'd0) &&
                     ((Rs1D == RdE) || (Rs2D == RdE));
  assign wait_last = (wait_cnt == CW'(MDU_TIMEOUT - 1));

  // Memory stage is the younger result, so it wins over Writeback.
  always_comb begin
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    if (rst_n) begin
      if (RegWriteM && (RdM != 5'd0) && (RdM == Rs1E))      ForwardAE = 2'b10;
      else if (RegWriteW && (RdW != 5'd0) && (RdW == Rs1E)) ForwardAE = 2'b01;
      if (RegWriteM && (RdM != 5'd0) && (RdM == Rs2E))      ForwardBE = 2'b10;
      else if (RegWriteW && (RdW != 5'd0) && (RdW == Rs2E)) ForwardBE = 2'b01;
    end
  end

  always_comb begin
    // NOTE: every output gets a default before the case so no path can infer a latch.
    StallF     = 1'b0;
    StallD     = 1'b0;
    StallE     = 1'b0;
    FlushD     = 1'b0;
    FlushE     = 1'b0;
    BubbleM    = 1'b0;
    mdu_start  = 1'b0;
    halted     = 1'b0;
    state_next = state;
    if (!rst_n) begin
      FlushD     = 1'b1;
      FlushE     = 1'b1;
      state_next = S_RUN;
    end else begin
      case (state)
        // STEP behaves like RUN except it cannot re-enter HALTED itself.
        S_RUN, S_STEP: begin
          state_next = S_RUN;
          if (mdu_opE) begin
            StallF     = 1'b1;
            StallD     = 1'b1;
            StallE     = 1'b1;
            BubbleM    = 1'b1;
            mdu_start  = 1'b1;
            state_next = S_MDU_WAIT;
          end else if (PCSrcE) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
          end else if (lw_stall) begin
            StallF = 1'b1;
            StallD = 1'b1;
            FlushE = 1'b1;
          end else if (halt_req && (state == S_RUN)) begin
            StallF     = 1'b1;
            StallD     = 1'b1;
            FlushE     = 1'b1;
            state_next = S_HALTED;
          end
        end
        S_MDU_WAIT: begin
          if (mdu_done || wait_last) begin
            state_next = S_RUN;
          end else begin
            StallF  = 1'b1;
            StallD  = 1'b1;
            StallE  = 1'b1;
            BubbleM = 1'b1;
          end
        end
        S_HALTED: begin
          StallF = 1'b1;
          StallD = 1'b1;
          FlushE = 1'b1;
          halted = 1'b1;
          if (!halt_req)     state_next = S_RUN;
          else if (step_req) state_next = S_STEP;
        end
        default: state_next = S_RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!rst_n) begin
      state     <= S_RUN;
      wait_cnt  <= '0;
      stall_cnt <= '0;
      mdu_err   <= 1'b0;
    end else begin
      state <= state_next;
      // Held at zero outside MDU_WAIT, so it always starts from zero on entry.
      if (state == S_MDU_WAIT) wait_cnt <= wait_cnt + 1'b1;
      else                     wait_cnt <= '0;
      if (StallD) stall_cnt <= stall_cnt + 32'd1;
      if ((state == S_MDU_WAIT) && wait_last && !mdu_done) mdu_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_sequencer.sv
// Directed-vector bench for hazard_sequencer; inputs change just after the
// rising edge and outputs are sampled on the falling edge.
module tb_hazard_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic [1:0]  ResultSrcE;
  logic        PCSrcE, mdu_opE, mdu_done, RegWriteM, RegWriteW, halt_req, step_req;
  logic        StallF, StallD, StallE, FlushD, FlushE, BubbleM;
  logic [1:0]  ForwardAE, ForwardBE;
  logic        mdu_start, halted, mdu_err;
  logic [31:0] stall_cnt;

  int          vectors     = 0;
  int          miscompares = 0;
  logic [31:0] exp_sc;

  hazard_sequencer #(.MDU_TIMEOUT(40)) dut (
    .clk(clk), .rst_n(rst_n),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
    .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE), .mdu_opE(mdu_opE), .mdu_done(mdu_done),
    .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .halt_req(halt_req), .step_req(step_req),
    .StallF(StallF), .StallD(StallD), .StallE(StallE),
    .FlushD(FlushD), .FlushE(FlushE), .BubbleM(BubbleM),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .mdu_start(mdu_start), .halted(halted), .mdu_err(mdu_err), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Control bits packed as {StallF, StallD, StallE, FlushD, FlushE, BubbleM}.
  task automatic chk_ctl(input string tag, input logic [5:0] exp);
    check(tag, {26'd0, StallF, StallD, StallE, FlushD, FlushE, BubbleM}, {26'd0, exp});
  endtask

  task automatic idle();
    Rs1D = '0; Rs2D = '0; Rs1E = '0; Rs2E = '0; RdE = '0; RdM = '0; RdW = '0;
    ResultSrcE = 2'b00; PCSrcE = 1'b0; mdu_opE = 1'b0; mdu_done = 1'b0;
    RegWriteM = 1'b0; RegWriteW = 1'b0; halt_req = 1'b0; step_req = 1'b0;
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic fwd(input string tag, input logic [4:0] rdm, input logic wm,
                     input logic [4:0] rdw, input logic ww, input logic [4:0] r1,
                     input logic [4:0] r2, input logic [1:0] ea, input logic [1:0] eb);
    cycle(); idle();
    RdM = rdm; RegWriteM = wm; RdW = rdw; RegWriteW = ww; Rs1E = r1; Rs2E = r2;
    @(negedge clk);
    check({tag, "_a"}, {30'd0, ForwardAE}, {30'd0, ea});
    check({tag, "_b"}, {30'd0, ForwardBE}, {30'd0, eb});
  endtask

  // Enter MDU_WAIT and hold it for 39 stalled cycles; the next cycle is the last one.
  task automatic mdu_to_last(input string tag);
    cycle(); idle(); mdu_opE = 1'b1;
    @(negedge clk);
    chk_ctl({tag, "_start_ctl"}, 6'b111_001);
    check({tag, "_start"}, {31'd0, mdu_start}, 32'd1);
    exp_sc++;
    for (int i = 0; i < 39; i++) begin
      cycle(); idle(); mdu_opE = 1'b1;
      @(negedge clk);
      chk_ctl({tag, "_wait_ctl"}, 6'b111_001);
      check({tag, "_wait_start"}, {31'd0, mdu_start}, 32'd0);
      exp_sc++;
    end
  endtask

  initial begin
    // Reset overrides active hazards and forwarding matches.
    rst_n = 1'b0; idle();
    halt_req = 1'b1; mdu_opE = 1'b1; RegWriteM = 1'b1; RdM = 5'd7; Rs1E = 5'd7;
    @(negedge clk);
    chk_ctl("reset_ctl", 6'b000_110);
    check("reset_start", {31'd0, mdu_start}, 32'd0);
    check("reset_halted", {31'd0, halted}, 32'd0);
    check("reset_fwd_a", {30'd0, ForwardAE}, 32'd0);
    cycle();
    @(negedge clk);
    check("reset_stall_cnt", stall_cnt, 32'd0);
    check("reset_err", {31'd0, mdu_err}, 32'd0);
    cycle(); rst_n = 1'b1; idle();
    @(negedge clk);
    exp_sc = 32'd0;
    chk_ctl("run_idle", 6'b000_000);
    check("run_halted", {31'd0, halted}, 32'd0);

    fwd("fwd_prio",  5'd7, 1'b1, 5'd7, 1'b1, 5'd7, 5'd0, 2'b10, 2'b00);
    fwd("fwd_rs0",   5'd7, 1'b1, 5'd7, 1'b1, 5'd0, 5'd0, 2'b00, 2'b00);
    fwd("fwd_x0",    5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 5'd0, 2'b00, 2'b00);
    fwd("fwd_wb",    5'd7, 1'b0, 5'd7, 1'b1, 5'd7, 5'd7, 2'b01, 2'b01);
    fwd("fwd_split", 5'd3, 1'b1, 5'd9, 1'b1, 5'd3, 5'd9, 2'b10, 2'b01);
    fwd("fwd_nowr",  5'd3, 1'b0, 5'd9, 1'b0, 5'd3, 5'd9, 2'b00, 2'b00);

    // Load-use on Rs1D, then on Rs2D, then cases that must not stall.
    cycle(); idle(); ResultSrcE = 2'b01; RdE = 5'd5; Rs1D = 5'd5;
    @(negedge clk); chk_ctl("lw_rs1", 6'b110_010); exp_sc++;
    cycle(); idle();
    @(negedge clk); chk_ctl("lw_after", 6'b000_000);
    check("lw_stall_cnt", stall_cnt, exp_sc);
    cycle(); idle(); ResultSrcE = 2'b01; RdE = 5'd12; Rs2D = 5'd12;
    @(negedge clk); chk_ctl("lw_rs2", 6'b110_010); exp_sc++;
    cycle(); idle(); ResultSrcE = 2'b01; RdE = 5'd0; Rs1D = 5'd0;
    @(negedge clk); chk_ctl("lw_x0", 6'b000_000);
    cycle(); idle(); ResultSrcE = 2'b10; RdE = 5'd5; Rs1D = 5'd5;
    @(negedge clk); chk_ctl("not_load", 6'b000_000);

    // Taken branch beats a simultaneous load-use.
    cycle(); idle(); PCSrcE = 1'b1; ResultSrcE = 2'b01; RdE = 5'd5; Rs1D = 5'd5;
    @(negedge clk); chk_ctl("br_lw", 6'b000_110);
    check("br_stall_cnt", stall_cnt, exp_sc);

    // MDU completing after four stalled MDU_WAIT cycles.
    cycle(); idle(); mdu_opE = 1'b1;
    @(negedge clk); chk_ctl("mdu_start_ctl", 6'b111_001);
    check("mdu_start", {31'd0, mdu_start}, 32'd1); exp_sc++;
    for (int i = 0; i < 4; i++) begin
      cycle(); idle(); mdu_opE = 1'b1;
      @(negedge clk); chk_ctl("mdu_wait_ctl", 6'b111_001);
      check("mdu_wait_start", {31'd0, mdu_start}, 32'd0); exp_sc++;
    end
    cycle(); idle(); mdu_opE = 1'b1; mdu_done = 1'b1;
    @(negedge clk); chk_ctl("mdu_done_ctl", 6'b000_000);
    check("mdu_done_start", {31'd0, mdu_start}, 32'd0);
    cycle(); idle();
    @(negedge clk); chk_ctl("mdu_after", 6'b000_000);
    check("mdu_stall_cnt", stall_cnt, exp_sc);
    check("mdu_no_err", {31'd0, mdu_err}, 32'd0);

    // Halt, single step, re-halt.
    cycle(); idle(); halt_req = 1'b1;
    @(negedge clk); chk_ctl("halt_enter", 6'b110_010);
    check("halt_enter_h", {31'd0, halted}, 32'd0); exp_sc++;
    cycle(); idle(); halt_req = 1'b1;
    @(negedge clk); chk_ctl("halted_ctl", 6'b110_010);
    check("halted_h", {31'd0, halted}, 32'd1); exp_sc++;
    cycle(); idle(); halt_req = 1'b1; step_req = 1'b1;
    @(negedge clk); check("step_req_h", {31'd0, halted}, 32'd1); exp_sc++;
    cycle(); idle(); halt_req = 1'b1;
    @(negedge clk); chk_ctl("step_ctl", 6'b000_000);
    check("step_h", {31'd0, halted}, 32'd0);
    cycle(); idle(); halt_req = 1'b1;
    @(negedge clk); chk_ctl("rehalt_ctl", 6'b110_010);
    check("rehalt_h", {31'd0, halted}, 32'd0); exp_sc++;
    cycle(); idle(); halt_req = 1'b1;
    @(negedge clk); check("rehalted_h", {31'd0, halted}, 32'd1); exp_sc++;
    // Releasing halt wins over a simultaneous step request.
    cycle(); idle(); step_req = 1'b1;
    @(negedge clk); check("release_h", {31'd0, halted}, 32'd1); exp_sc++;
    cycle(); idle(); halt_req = 1'b1;
    @(negedge clk); chk_ctl("release_run", 6'b110_010); exp_sc++;
    cycle(); idle(); halt_req = 1'b1;
    @(negedge clk); check("halt2_h", {31'd0, halted}, 32'd1); exp_sc++;
    // Step into an MDU operation.
    cycle(); idle(); halt_req = 1'b1; step_req = 1'b1;
    @(negedge clk); exp_sc++;
    cycle(); idle(); halt_req = 1'b1; mdu_opE = 1'b1;
    @(negedge clk); chk_ctl("step_mdu_ctl", 6'b111_001);
    check("step_mdu_start", {31'd0, mdu_start}, 32'd1);
    check("step_mdu_h", {31'd0, halted}, 32'd0); exp_sc++;
    cycle(); idle(); halt_req = 1'b1; mdu_opE = 1'b1; mdu_done = 1'b1;
    @(negedge clk); chk_ctl("step_mdu_done", 6'b000_000);
    cycle(); idle(); halt_req = 1'b1;
    @(negedge clk); chk_ctl("step_mdu_rehalt", 6'b110_010); exp_sc++;
    cycle(); idle();
    @(negedge clk); check("halt3_h", {31'd0, halted}, 32'd1); exp_sc++;
    cycle(); idle();
    @(negedge clk); chk_ctl("halt3_out", 6'b000_000);
    check("halt_stall_cnt", stall_cnt, exp_sc);

    // A step request outside HALTED leaves the core in RUN.
    cycle(); idle(); step_req = 1'b1;
    @(negedge clk); chk_ctl("step_in_run", 6'b000_000);
    cycle(); idle(); halt_req = 1'b1;
    @(negedge clk); chk_ctl("step_ignored", 6'b110_010); exp_sc++;
    cycle(); idle();
    @(negedge clk); check("step_ign_h", {31'd0, halted}, 32'd1); exp_sc++;
    cycle(); idle();
    @(negedge clk); check("step_ign_sc", stall_cnt, exp_sc);

    // Done arriving in the timeout cycle is a normal completion.
    mdu_to_last("lastdone");
    cycle(); idle(); mdu_opE = 1'b1; mdu_done = 1'b1;
    @(negedge clk); chk_ctl("lastdone_rel", 6'b000_000);
    cycle(); idle();
    @(negedge clk); check("lastdone_err", {31'd0, mdu_err}, 32'd0);
    check("lastdone_sc", stall_cnt, exp_sc);

    // Timeout without done: release in the 40th MDU_WAIT cycle, sticky error.
    mdu_to_last("tmo");
    cycle(); idle(); mdu_opE = 1'b1;
    @(negedge clk); chk_ctl("tmo_rel", 6'b000_000);
    check("tmo_err_pre", {31'd0, mdu_err}, 32'd0);
    cycle(); idle();
    @(negedge clk); check("tmo_err", {31'd0, mdu_err}, 32'd1);
    chk_ctl("tmo_run", 6'b000_000);
    check("tmo_sc", stall_cnt, exp_sc);
    for (int i = 0; i < 3; i++) begin
      cycle(); idle(); ResultSrcE = 2'b01; RdE = 5'd4; Rs2D = 5'd4;
      @(negedge clk); check("tmo_err_sticky", {31'd0, mdu_err}, 32'd1);
    end

    // Reset while in MDU_WAIT.
    cycle(); idle(); mdu_opE = 1'b1;
    @(negedge clk);
    cycle(); idle(); mdu_opE = 1'b1;
    @(negedge clk); chk_ctl("rmdu_wait", 6'b111_001);
    cycle(); rst_n = 1'b0;
    @(negedge clk); chk_ctl("rmdu_rst", 6'b000_110);
    check("rmdu_start", {31'd0, mdu_start}, 32'd0);
    cycle(); rst_n = 1'b1; idle();
    @(negedge clk); chk_ctl("rmdu_run", 6'b000_000);
    check("rmdu_err", {31'd0, mdu_err}, 32'd0);
    check("rmdu_sc", stall_cnt, 32'd0);

    // Reset while HALTED.
    cycle(); idle(); halt_req = 1'b1;
    @(negedge clk);
    cycle(); idle(); halt_req = 1'b1;
    @(negedge clk); check("rhalt_pre", {31'd0, halted}, 32'd1);
    cycle(); rst_n = 1'b0;
    @(negedge clk); check("rhalt_rst", {31'd0, halted}, 32'd0);
    cycle(); rst_n = 1'b1; idle();
    @(negedge clk); chk_ctl("rhalt_run", 6'b000_000);
    check("rhalt_h", {31'd0, halted}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
